// File: rtl/step_viewer_disp.sv
// Multiplexed 7-segment viewer for solver moves: two letter digits for the current
// move, DIGITS-2 decimal digits for the step index, with button browsing and auto-play.
module step_viewer_disp #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned STEP_W    = 5,
    parameter int unsigned MAX_STEPS = 20,
    parameter int unsigned SCAN_DIV  = 4096,
    parameter int unsigned AUTO_DIV  = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comp,
    input  logic [STEP_W-1:0]      cnt,
    input  logic [2*MAX_STEPS-1:0] ord,
    input  logic [4:0]             btn,
    output logic [DIGITS+7:0]      seg,
    output logic [STEP_W-1:0]      step,
    output logic                   auto_on
);

    localparam int unsigned NUM_DIG = DIGITS - 2;
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned DIG_W   = $clog2(DIGITS);
    localparam int unsigned AUTO_W  = $clog2(AUTO_DIV + 1);

    localparam logic [7:0] G_U    = 8'hC1;
    localparam logic [7:0] G_P    = 8'h8C;
    localparam logic [7:0] G_D    = 8'hA1;
    localparam logic [7:0] G_O    = 8'hA3;
    localparam logic [7:0] G_L    = 8'hC7;
    localparam logic [7:0] G_E    = 8'h86;
    localparam logic [7:0] G_R    = 8'hAF;
    localparam logic [7:0] G_I    = 8'hFB;
    localparam logic [7:0] G_S    = 8'h92;
    localparam logic [7:0] G_DASH = 8'hBF;

    localparam int unsigned B_LAST  = 0;
    localparam int unsigned B_FIRST = 1;
    localparam int unsigned B_AUTO  = 2;
    localparam int unsigned B_PREV  = 3;
    localparam int unsigned B_NEXT  = 4;

    function automatic logic [7:0] num_glyph(input logic [3:0] d);
        case (d)
            4'd0:    num_glyph = 8'hC0;
            4'd1:    num_glyph = 8'hF9;
            4'd2:    num_glyph = 8'hA4;
            4'd3:    num_glyph = 8'hB0;
            4'd4:    num_glyph = 8'h99;
            4'd5:    num_glyph = 8'h92;
            4'd6:    num_glyph = 8'h82;
            4'd7:    num_glyph = 8'hF8;
            4'd8:    num_glyph = 8'h80;
            4'd9:    num_glyph = 8'h90;
            default: num_glyph = 8'hFF;
        endcase
    endfunction

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [DIGITS+7:0] seg_q, seg_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              auto_q, auto_d;
    logic [AUTO_W-1:0] acnt_q, acnt_d;
    logic [4:0]        sync1_q, sync2_q, hist_q, hist_d;
    logic              comp_q;

    logic              tick_c;
    logic [4:0]        press_c;
    logic [STEP_W-1:0] last_c;
    int unsigned       eff_cnt;
    logic [1:0]        move_c;
    logic [3:0]        bcd_c [NUM_DIG];
    int unsigned       bcd_v;
    logic [7:0]        let_hi_c, let_lo_c, glyph_c;

    // Scan timing and button press detection (presses only count on scan ticks)
    always_comb begin
        tick_c  = (scan_q == SCAN_W'(SCAN_DIV - 1));
        scan_d  = tick_c ? '0 : scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (tick_c) begin
            digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
        end
        hist_d  = tick_c ? sync2_q : hist_q;
        press_c = sync2_q & ~hist_q & {5{tick_c}};
        eff_cnt = (32'(cnt) > MAX_STEPS) ? MAX_STEPS : 32'(cnt);
        last_c  = STEP_W'(eff_cnt - 1);
    end

    // Step / auto-play control; one action per tick, first > last > next > prev > auto
    always_comb begin
        step_d = step_q;
        auto_d = auto_q;
        acnt_d = acnt_q;
        if (!comp || (cnt == '0) || !comp_q) begin
            step_d = '0;
            auto_d = 1'b0;
            acnt_d = '0;
        end else if (tick_c) begin
            if (press_c[B_FIRST]) begin
                step_d = '0;
                auto_d = 1'b0;
            end else if (press_c[B_LAST]) begin
                step_d = last_c;
                auto_d = 1'b0;
            end else if (press_c[B_NEXT]) begin
                if (step_q < last_c) step_d = step_q + STEP_W'(1);
                auto_d = 1'b0;
            end else if (press_c[B_PREV]) begin
                if (step_q != '0) step_d = step_q - STEP_W'(1);
                auto_d = 1'b0;
            end else if (press_c[B_AUTO]) begin
                auto_d = ~auto_q;
                acnt_d = '0;
            end else if (auto_q) begin
                if (acnt_q == AUTO_W'(AUTO_DIV - 1)) begin
                    acnt_d = '0;
                    if (step_q < last_c) step_d = step_q + STEP_W'(1);
                    if (step_d >= last_c) auto_d = 1'b0;
                end else begin
                    acnt_d = acnt_q + AUTO_W'(1);
                end
            end
        end
    end

    // Display buffer: letters from the move code, number digits from binary-to-BCD
    always_comb begin
        move_c = 2'(ord >> (32'(step_q) * 2));
        bcd_v  = 32'(step_q);
        for (int i = 0; i < NUM_DIG; i++) begin
            bcd_c[i] = 4'(bcd_v % 10);
            bcd_v    = bcd_v / 10;
        end
        if (!comp) begin
            let_hi_c = G_S;
            let_lo_c = G_O;
        end else if (cnt == '0) begin
            let_hi_c = G_DASH;
            let_lo_c = G_DASH;
        end else begin
            case (move_c)
                2'b00:   begin let_hi_c = G_U; let_lo_c = G_P; end
                2'b01:   begin let_hi_c = G_D; let_lo_c = G_O; end
                2'b10:   begin let_hi_c = G_L; let_lo_c = G_E; end
                default: begin let_hi_c = G_R; let_lo_c = G_I; end
            endcase
        end
        glyph_c = 8'hFF;
        if (digit_q == DIG_W'(DIGITS - 1)) begin
            glyph_c = let_hi_c;
        end else if (digit_q == DIG_W'(DIGITS - 2)) begin
            glyph_c = let_lo_c;
        end else begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (digit_q == DIG_W'(i)) glyph_c = comp ? num_glyph(bcd_c[i]) : G_DASH;
            end
        end
        seg_d = tick_c ? {~(DIGITS'(1) << digit_q), glyph_c} : seg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            digit_q <= '0;
            seg_q   <= '1;
            step_q  <= '0;
            auto_q  <= 1'b0;
            acnt_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            comp_q  <= 1'b0;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            step_q  <= step_d;
            auto_q  <= auto_d;
            acnt_q  <= acnt_d;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            comp_q  <= comp;
        end
    end

    assign seg     = seg_q;
    assign step    = step_q;
    assign auto_on = auto_q;

endmodule

// File: tb/tb_step_viewer_disp.sv
// Self-checking bench for step_viewer_disp: step changes are scoreboarded against
// an expected queue, display frames are compared glyph by glyph.
module tb_step_viewer_disp;

    logic        clk;
    logic        rst_n;
    logic        comp;
    logic [4:0]  cnt;
    logic [39:0] ord;
    logic [4:0]  btn;
    logic [11:0] seg;
    logic [4:0]  step;
    logic        auto_on;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [4:0]  exp_q [$];
    logic [4:0]  last_step = '0;
    logic        sb_en = 1'b1;

    step_viewer_disp #(
        .DIGITS(4), .STEP_W(5), .MAX_STEPS(20), .SCAN_DIV(4), .AUTO_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .comp(comp), .cnt(cnt), .ord(ord),
        .btn(btn), .seg(seg), .step(step), .auto_on(auto_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Step monitor: every change must match the head of the expected queue
    always @(negedge clk) begin
        logic [4:0] e;
        if (step !== last_step) begin
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    chk("step_unexpected", 32'(step), 32'(last_step));
                end else begin
                    e = exp_q.pop_front();
                    chk("step_sb", 32'(step), 32'(e));
                end
            end
            last_step = step;
        end
    end

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (8) @(posedge clk);
        btn[b] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic press_exp(input int b, input logic [4:0] e);
        exp_q.push_back(e);
        press(b);
    endtask

    task automatic wait_sb(input int max_clk);
        for (int i = 0; i < max_clk && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic disp(input logic [7:0] g3, input logic [7:0] g2,
                        input logic [7:0] g1, input logic [7:0] g0);
        logic [7:0] g [4];
        logic [3:0] an;
        logic       found;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        found = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (seg[11:8] == 4'b1110) found = 1'b1;
        end
        chk("disp_sync", 32'(found), 32'd1);
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            chk("disp_digit", 32'(seg), 32'({an, g[d]}));
            if (d < 3) begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [11:0] frames [5];
        logic [4:0]  s;
        rst_n = 1'b0;
        comp  = 1'b0;
        cnt   = '0;
        ord   = '0;
        ord[7:6]   = 2'b10;
        ord[23:22] = 2'b11;
        btn   = '0;
        frames[0] = {4'b1110, 8'hBF};
        frames[1] = {4'b1101, 8'hBF};
        frames[2] = {4'b1011, 8'hA3};
        frames[3] = {4'b0111, 8'h92};
        frames[4] = {4'b1110, 8'hBF};

        // Reset state and first scan cycle
        #22;
        chk("rst_seg", 32'(seg), 32'hFFF);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_auto", 32'(auto_on), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("seg_before_tick", 32'(seg), 32'hFFF);
        for (int f = 0; f < 5; f++) begin
            @(posedge clk);
            #1;
            chk("scan_frame", 32'(seg), 32'(frames[f]));
            if (f < 4) repeat (3) @(posedge clk);
        end

        // Solver not done: presses ignored
        press(4);
        chk("comp0_next", 32'(step), 32'd0);

        // Done but no moves
        comp = 1'b1;
        press(4);
        chk("cnt0_next", 32'(step), 32'd0);
        disp(8'hBF, 8'hBF, 8'hC0, 8'hC0);

        // Browse forward
        cnt = 5'd12;
        press_exp(4, 5'd1);
        press_exp(4, 5'd2);
        press_exp(4, 5'd3);
        wait_sb(20);
        chk("step3", 32'(step), 32'd3);
        disp(8'hC7, 8'h86, 8'hC0, 8'hB0);
        for (int i = 4; i <= 11; i++) press_exp(4, 5'(i));
        press(4);
        wait_sb(20);
        chk("next_hold_at_L", 32'(step), 32'd11);
        disp(8'hAF, 8'hFB, 8'hF9, 8'hF9);

        // first / prev at 0 / last / first, then a long hold
        press_exp(1, 5'd0);
        press(3);
        chk("prev_at_0", 32'(step), 32'd0);
        press_exp(0, 5'd11);
        press_exp(1, 5'd0);
        exp_q.push_back(5'd1);
        btn[4] = 1'b1;
        repeat (40) @(posedge clk);
        btn[4] = 1'b0;
        repeat (8) @(posedge clk);
        wait_sb(20);
        chk("hold_one_inc", 32'(step), 32'd1);

        // Auto-play from 9 runs to L and stops
        press_exp(0, 5'd11);
        press_exp(3, 5'd10);
        press_exp(3, 5'd9);
        exp_q.push_back(5'd10);
        exp_q.push_back(5'd11);
        press(2);
        wait_sb(200);
        chk("auto_end_off", 32'(auto_on), 32'd0);
        chk("auto_end_step", 32'(step), 32'd11);

        // A manual press during auto-play stops it
        sb_en = 1'b0;
        press(1);
        press(2);
        chk("auto_running", 32'(auto_on), 32'd1);
        press(3);
        chk("prev_clears_auto", 32'(auto_on), 32'd0);
        s = step;
        repeat (40) @(posedge clk);
        #1;
        chk("auto_stopped", 32'(step), 32'(s));

        // Async reset at step 7 with auto-play active
        press(1);
        for (int i = 0; i < 7; i++) press(4);
        chk("step7", 32'(step), 32'd7);
        btn[2] = 1'b1;
        for (int i = 0; i < 40 && !auto_on; i++) begin
            @(posedge clk);
            #1;
        end
        chk("auto_on_at7", 32'(auto_on), 32'd1);
        chk("still7", 32'(step), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("async_step", 32'(step), 32'd0);
        chk("async_auto", 32'(auto_on), 32'd0);
        chk("async_seg", 32'(seg), 32'hFFF);
        btn  = '0;
        comp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        comp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("comp_rise_step", 32'(step), 32'd0);
        chk("comp_rise_auto", 32'(auto_on), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/step_viewer_disp.md
Name: step_viewer_disp

Overview:
Parametrised successor to the puzzle I/O display block. It drives a DIGITS-wide multiplexed 7-segment display showing the current solution move (2 letter digits) and the zero-based step index (DIGITS-2 decimal digits). Users browse steps with synchronised, edge-detected buttons, and an auto-play mode advances steps on a timer. It sits between the solver (comp, cnt, ord) and the board pins.

Parameters:
DIGITS, 4, total display digits (min 3); digits DIGITS-1..DIGITS-2 are letters, the rest are decimal step index
STEP_W, 5, width of step count/index
MAX_STEPS, 20, capacity of ord (2 bits per move)
SCAN_DIV, 4096, clk cycles per scan tick (min 2)
AUTO_DIV, 256, scan ticks per auto-play step (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
comp  in  1  solver done; level
cnt  in  STEP_W  number of valid moves in ord
ord  in  2*MAX_STEPS  move list; move i at bits [2i+1:2i]
btn  in  5  raw buttons, active-high: [4] next, [3] prev, [2] auto toggle, [1] first, [0] last
seg  out  DIGITS+8  [DIGITS+7:8] anode select (active-low, one-hot-low), [7:0] {dp, g..a} (active-low)
step  out  STEP_W  current step index
auto_on  out  1  auto-play active

Behaviour:
- Reset (async, rst_n=0): seg = all ones (blank, no anode), step=0, auto_on=0, scan counter=0, digit=0, button sync/history regs=0, auto counter=0.
- Scan tick: 1-cycle pulse when the free-running counter (0..SCAN_DIV-1) wraps to 0. On each tick, seg is registered from the buffer for the current digit, and digit advances 0..DIGITS-1 then wraps to 0. Anode pattern is ~(1<<digit).
- Buttons: 2-flop synchroniser per bit, sampled into a history reg only on scan ticks. Press = sampled 1 while history 0. Only one action per tick, with priority first > last > next > prev > auto toggle.
- Effective last index L = min(cnt, MAX_STEPS)-1. If cnt=0, L is undefined, step holds 0, and all presses are ignored.
- next: step+1 if step<L, else hold. prev: step-1 if step>0, else hold. first: step=0. last: step=L.
- Auto toggle: flips auto_on and clears the auto counter. While auto_on, the counter counts scan ticks. At AUTO_DIV it advances step by 1 and clears. Reaching L clears auto_on. Any manual next/prev/first/last press clears auto_on.
- comp=0: buttons ignored, auto_on forced 0, step forced 0.
- Rising edge of comp: step=0, auto_on=0.
- Letter digits:
  - comp=0: "S","o".
  - comp=1, cnt=0: "-","-".
  - Otherwise by move code: 00 "U","P"; 01 "d","o"; 10 "L","E"; 11 "r","i".
- Number digits: comp=1 shows step in decimal with leading zeros, least significant digit at digit 0, via combinational binary-to-BCD. comp=0 shows "-" on every number digit.
- Glyphs (dp,g..a active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 U=C1 P=8C d=A1 o=A3 L=C7 E=86 r=AF i=FB S=92 -=BF. dp is always off.
- Step index overflow: values above 10^(DIGITS-2)-1 display modulo 10^(DIGITS-2).
- Buffer changes take effect at the next scan tick for that digit; maximum display latency is DIGITS scan ticks.

Test Plan:
- Reset then release, SCAN_DIV=4: seg is all ones until the first tick. Anodes then cycle 1110,1101,1011,0111,1110 with one tick every 4 clk.
- comp=0, press next: step stays 0. Display shows S, o, "-", "-" (92,A3,BF,BF on digits 3..0).
- comp=1, cnt=12, ord move3=2'b10: press next x3 gives step=3 and display "LE03". Press next 9 more times: step holds at 11. Press prev at step 0: step holds at 0.
- cnt=12, press last then first: step goes 11 then 0. Hold next for 10 ticks: exactly one increment.
- AUTO_DIV=2, press auto at step 9, cnt=12: step becomes 10 after 2 ticks, then 11, then auto_on=0. A prev press mid-run clears auto_on.
- Assert rst_n=0 mid-scan at step 7 with auto_on=1: outputs clear immediately without a clk edge. comp rise after release gives step=0.
